// File: rtl/ctrl_sequencer_if.sv
// Handshake and stage-enable bundle between the instruction sequencer and the
// surrounding bus-wait logic / datapath. The master side is the sequencer itself;
// the slave side is whatever supplies stall/request inputs and consumes enables.
interface ctrl_sequencer_if #(
    parameter int STATE_W    = 10,
    parameter int WAIT_CNT_W = 8
);
    logic                  need_wait;
    logic                  mem_req;
    logic                  wb_req;
    logic                  halt_req;
    logic                  resume;
    logic                  fetch_en;
    logic                  decode_en;
    logic                  alu_en;
    logic                  mem_en;
    logic                  reg_write_en;
    logic                  incr_pc;
    logic                  retire;
    logic                  halted;
    logic                  timeout_err;
    logic [WAIT_CNT_W-1:0] wait_count;
    logic [STATE_W-1:0]    dbg_state;

    modport master (
        input  need_wait, mem_req, wb_req, halt_req, resume,
        output fetch_en, decode_en, alu_en, mem_en, reg_write_en,
               incr_pc, retire, halted, timeout_err, wait_count, dbg_state
    );

    modport slave (
        output need_wait, mem_req, wb_req, halt_req, resume,
        input  fetch_en, decode_en, alu_en, mem_en, reg_write_en,
               incr_pc, retire, halted, timeout_err, wait_count, dbg_state
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// Multi-cycle instruction sequencer. Walks FETCH -> DECODE -> ALU -> [MEM] ->
// [REG_WRITE], skipping MEM / REG_WRITE per instruction, with a halt/resume
// handshake at instruction boundaries and a stall watchdog that parks the core
// in HALT when a single stage is held too long.
module ctrl_sequencer #(
    parameter int STATE_W    = 10,
    parameter int WAIT_CNT_W = 8,
    parameter int MAX_WAIT   = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    ctrl_sequencer_if.master bus
);

    typedef enum logic [5:0] {
        FETCH     = 6'h01,
        DECODE    = 6'h02,
        ALU       = 6'h04,
        MEM       = 6'h08,
        REG_WRITE = 6'h10,
        HALT      = 6'h20
    } state_t;

    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX  = WAIT_CNT_W'(MAX_WAIT);
    localparam logic [WAIT_CNT_W-1:0] WAIT_TRIP = WAIT_CNT_W'(MAX_WAIT - 1);

    // The state register is a plain vector so that corrupted, non-one-hot values
    // remain representable and can be steered back to FETCH.
    logic [5:0]            state_q;
    logic [5:0]            state_d;
    logic                  mem_flag_q;
    logic                  wb_flag_q;
    logic [WAIT_CNT_W-1:0] wait_count_q;
    logic                  timeout_q;
    logic                  stalled;
    logic                  boundary;
    logic                  trip;
    logic                  incr_pc;
    logic                  retire;

    // Next-state decode, boundary handling and watchdog override.
    always_comb begin
        state_d  = state_q;
        incr_pc  = 1'b0;
        retire   = 1'b0;
        boundary = 1'b0;
        stalled  = 1'b0;
        trip     = 1'b0;

        case (state_q)
            FETCH: begin
                if (bus.need_wait) stalled = 1'b1;
                else               state_d = DECODE;
            end
            DECODE: begin
                if (bus.need_wait) begin
                    stalled = 1'b1;
                end else begin
                    state_d = ALU;
                    incr_pc = 1'b1;
                end
            end
            ALU: begin
                if (bus.need_wait)  stalled  = 1'b1;
                else if (mem_flag_q) state_d = MEM;
                else if (wb_flag_q)  state_d = REG_WRITE;
                else                 boundary = 1'b1;
            end
            MEM: begin
                if (bus.need_wait)  stalled  = 1'b1;
                else if (wb_flag_q) state_d  = REG_WRITE;
                else                boundary = 1'b1;
            end
            REG_WRITE: begin
                if (bus.need_wait) stalled  = 1'b1;
                else               boundary = 1'b1;
            end
            HALT: begin
                if (bus.resume) state_d = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if (boundary) begin
            retire  = 1'b1;
            state_d = bus.halt_req ? HALT : FETCH;
        end

        if (stalled && (wait_count_q == WAIT_TRIP)) begin
            trip    = 1'b1;
            state_d = HALT;
        end
    end

    // State register plus the per-instruction MEM/WB flags captured as DECODE retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            mem_flag_q <= 1'b0;
            wb_flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == DECODE) && !bus.need_wait) begin
                mem_flag_q <= bus.mem_req;
                wb_flag_q  <= bus.wb_req;
            end
        end
    end

    // Watchdog: count consecutive stalled edges in one stage, sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_count_q <= '0;
            timeout_q    <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                wait_count_q <= '0;
            end else if (stalled && (wait_count_q != WAIT_MAX)) begin
                wait_count_q <= wait_count_q + WAIT_CNT_W'(1);
            end
            if (trip) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.fetch_en     = (state_q == FETCH);
    assign bus.decode_en    = (state_q == DECODE);
    assign bus.alu_en       = (state_q == ALU);
    assign bus.mem_en       = (state_q == MEM);
    assign bus.reg_write_en = (state_q == REG_WRITE);
    assign bus.halted       = (state_q == HALT);
    assign bus.incr_pc      = incr_pc;
    assign bus.retire       = retire;
    assign bus.timeout_err  = timeout_q;
    assign bus.wait_count   = wait_count_q;
    assign bus.dbg_state    = STATE_W'(state_q);

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: walks instruction mixes, stalls, halt/resume,
// the stall watchdog, asynchronous reset and illegal-state recovery.
module tb_ctrl_sequencer;

    localparam logic [5:0] ST_F = 6'h01;
    localparam logic [5:0] ST_D = 6'h02;
    localparam logic [5:0] ST_A = 6'h04;
    localparam logic [5:0] ST_M = 6'h08;
    localparam logic [5:0] ST_W = 6'h10;
    localparam logic [5:0] ST_H = 6'h20;

    logic clk;
    logic rst_n;
    int   testCount = 0;
    int   failCount = 0;

    ctrl_sequencer_if #(.STATE_W(10), .WAIT_CNT_W(8)) bus ();

    ctrl_sequencer #(
        .STATE_W    (10),
        .WAIT_CNT_W (8),
        .MAX_WAIT   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the directed sequence ever wedges.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "[TB] global timeout");
    end

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        testCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic nw, input logic mr, input logic wr,
                                 input logic hr, input logic rs);
        bus.need_wait = nw;
        bus.mem_req   = mr;
        bus.wb_req    = wr;
        bus.halt_req  = hr;
        bus.resume    = rs;
    endtask

    task automatic checkOutput(input string tag, input logic [5:0] st, input logic inc,
                               input logic ret, input logic [7:0] wc, input logic to);
        cmp({tag, ":state"}, 16'(bus.dbg_state), 16'(st));
        cmp({tag, ":enables"}, 16'({bus.halted, bus.reg_write_en, bus.mem_en,
                                    bus.alu_en, bus.decode_en, bus.fetch_en}), 16'(st));
        cmp({tag, ":pulses"}, 16'({bus.incr_pc, bus.retire}), 16'({inc, ret}));
        cmp({tag, ":wait_count"}, 16'(bus.wait_count), 16'(wc));
        cmp({tag, ":timeout"}, 16'(bus.timeout_err), 16'(to));
    endtask

    task automatic stepCycle(input string tag,
                             input logic nw, input logic mr, input logic wr,
                             input logic hr, input logic rs,
                             input logic [5:0] st, input logic inc, input logic ret,
                             input logic [7:0] wc, input logic to);
        @(negedge clk);
        applyStimulus(nw, mr, wr, hr, rs);
        #1;
        checkOutput(tag, st, inc, ret, wc, to);
    endtask

    // Linear directed sequence: inputs set on the falling edge, checked 1 unit later.
    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        checkOutput("reset", ST_F, 0, 0, 8'd0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // WB-only instruction: F,D,A,RW
        stepCycle("wb_F",   0, 0, 1, 0, 0, ST_F, 0, 0, 8'd0, 0);
        stepCycle("wb_D",   0, 0, 1, 0, 0, ST_D, 1, 0, 8'd0, 0);
        stepCycle("wb_A",   0, 0, 0, 0, 0, ST_A, 0, 0, 8'd0, 0);
        stepCycle("wb_RW",  0, 0, 0, 0, 0, ST_W, 0, 1, 8'd0, 0);
        // MEM-only instruction: F,D,A,MEM
        stepCycle("mem_F",  0, 1, 0, 0, 0, ST_F, 0, 0, 8'd0, 0);
        stepCycle("mem_D",  0, 1, 0, 0, 0, ST_D, 1, 0, 8'd0, 0);
        stepCycle("mem_A",  0, 0, 0, 0, 0, ST_A, 0, 0, 8'd0, 0);
        stepCycle("mem_M",  0, 0, 0, 0, 0, ST_M, 0, 1, 8'd0, 0);
        // ALU-only instruction: retire on the ALU cycle
        stepCycle("alu_F",  0, 0, 0, 0, 0, ST_F, 0, 0, 8'd0, 0);
        stepCycle("alu_D",  0, 0, 0, 0, 0, ST_D, 1, 0, 8'd0, 0);
        stepCycle("alu_A",  0, 0, 0, 0, 0, ST_A, 0, 1, 8'd0, 0);
        // Three stalled cycles in MEM
        stepCycle("stl_F",  0, 1, 0, 0, 0, ST_F, 0, 0, 8'd0, 0);
        stepCycle("stl_D",  0, 1, 0, 0, 0, ST_D, 1, 0, 8'd0, 0);
        stepCycle("stl_A",  0, 0, 0, 0, 0, ST_A, 0, 0, 8'd0, 0);
        stepCycle("stl_M0", 1, 0, 0, 0, 0, ST_M, 0, 0, 8'd0, 0);
        stepCycle("stl_M1", 1, 0, 0, 0, 0, ST_M, 0, 0, 8'd1, 0);
        stepCycle("stl_M2", 1, 0, 0, 0, 0, ST_M, 0, 0, 8'd2, 0);
        stepCycle("stl_M3", 0, 0, 0, 0, 0, ST_M, 0, 1, 8'd3, 0);
        // halt_req raised during ALU, honoured at the boundary
        stepCycle("hlt_F",  0, 0, 1, 0, 0, ST_F, 0, 0, 8'd0, 0);
        stepCycle("hlt_D",  0, 0, 1, 0, 0, ST_D, 1, 0, 8'd0, 0);
        stepCycle("hlt_A",  0, 0, 0, 1, 0, ST_A, 0, 0, 8'd0, 0);
        stepCycle("hlt_RW", 0, 0, 0, 1, 0, ST_W, 0, 1, 8'd0, 0);
        stepCycle("hlt_H0", 0, 0, 0, 0, 0, ST_H, 0, 0, 8'd0, 0);
        stepCycle("hlt_H1", 1, 0, 0, 0, 0, ST_H, 0, 0, 8'd0, 0);
        stepCycle("hlt_H2", 0, 0, 0, 0, 1, ST_H, 0, 0, 8'd0, 0);
        // resume outside HALT is ignored
        stepCycle("rsm_F",  0, 0, 0, 0, 1, ST_F, 0, 0, 8'd0, 0);
        stepCycle("rsm_D",  0, 0, 0, 0, 0, ST_D, 1, 0, 8'd0, 0);
        stepCycle("rsm_A",  0, 0, 0, 1, 0, ST_A, 0, 1, 8'd0, 0);
        // halt_req and resume together in HALT: leave, then re-halt at next boundary
        stepCycle("hr_H",   0, 0, 0, 1, 1, ST_H, 0, 0, 8'd0, 0);
        stepCycle("hr_F",   0, 0, 0, 1, 0, ST_F, 0, 0, 8'd0, 0);
        stepCycle("hr_D",   0, 0, 0, 1, 0, ST_D, 1, 0, 8'd0, 0);
        stepCycle("hr_A",   0, 0, 0, 1, 0, ST_A, 0, 1, 8'd0, 0);
        stepCycle("hr_H2",  0, 0, 0, 0, 1, ST_H, 0, 0, 8'd0, 0);
        // Watchdog: need_wait stuck in DECODE with MAX_WAIT=4
        stepCycle("wd_F",   0, 1, 1, 0, 0, ST_F, 0, 0, 8'd0, 0);
        stepCycle("wd_D0",  1, 1, 1, 0, 0, ST_D, 0, 0, 8'd0, 0);
        stepCycle("wd_D1",  1, 1, 1, 0, 0, ST_D, 0, 0, 8'd1, 0);
        stepCycle("wd_D2",  1, 1, 1, 0, 0, ST_D, 0, 0, 8'd2, 0);
        stepCycle("wd_D3",  1, 1, 1, 0, 0, ST_D, 0, 0, 8'd3, 0);
        stepCycle("wd_H0",  1, 1, 1, 0, 0, ST_H, 0, 0, 8'd0, 1);
        stepCycle("wd_H1",  0, 1, 1, 0, 1, ST_H, 0, 0, 8'd0, 1);
        stepCycle("wd_F2",  0, 1, 1, 0, 0, ST_F, 0, 0, 8'd0, 1);
        stepCycle("wd_D4",  0, 1, 1, 0, 0, ST_D, 1, 0, 8'd0, 1);
        stepCycle("wd_A",   0, 0, 0, 0, 0, ST_A, 0, 0, 8'd0, 1);
        stepCycle("wd_M",   0, 0, 0, 0, 0, ST_M, 0, 0, 8'd0, 1);

        // Asynchronous reset mid-MEM, no clock edge in between
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst", ST_F, 0, 0, 8'd0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stepCycle("post_rst", 1, 0, 0, 0, 0, ST_F, 0, 0, 8'd0, 0);

        // Illegal non-one-hot state recovers to FETCH with no retire
        force dut.state_q = 6'h03;
        #1;
        cmp("illegal:state", 16'(bus.dbg_state), 16'h0003);
        cmp("illegal:enables", 16'({bus.halted, bus.reg_write_en, bus.mem_en,
                                    bus.alu_en, bus.decode_en, bus.fetch_en}), 16'h0000);
        cmp("illegal:pulses", 16'({bus.incr_pc, bus.retire}), 16'h0000);
        release dut.state_q;
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0);
        #1;
        cmp("recover:state", 16'(bus.dbg_state), 16'(ST_F));
        cmp("recover:pulses", 16'({bus.incr_pc, bus.retire}), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
